// File: rtl/jtcop_mcu_mbox_if.sv
// Signal bundle for jtcop_mcu_mbox: main-CPU command/reply side plus the MCU port-0 side.
// The master modport drives the bus inputs; the slave modport is the mailbox itself.
interface jtcop_mcu_mbox_if #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
);
    localparam int LANES = DW / 8;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW    = $clog2(DEPTH);

    logic          main_we;
    logic [DW-1:0] main_din;
    logic [DW-1:0] main_dout;
    logic          full;
    logic [CW:0]   level;
    logic          ovf;
    logic [LW-1:0] mcu_lane;
    logic          mcu_rd;
    logic          mcu_wr;
    logic          mcu_pop;
    logic          mcu_clr;
    logic [7:0]    mcu_p0o;
    logic [7:0]    mcu_p0i;
    logic          mcu_intn;

    modport master (
        output main_we, main_din, mcu_lane, mcu_rd, mcu_wr, mcu_pop, mcu_clr, mcu_p0o,
        input  main_dout, full, level, ovf, mcu_p0i, mcu_intn
    );

    modport slave (
        input  main_we, main_din, mcu_lane, mcu_rd, mcu_wr, mcu_pop, mcu_clr, mcu_p0o,
        output main_dout, full, level, ovf, mcu_p0i, mcu_intn
    );
endinterface

// File: rtl/jtcop_mcu_mbox.sv
// Main-CPU to i8751 mailbox: DEPTH-entry command FIFO, byte-lane reply register
// and level-based INT1, all in the clk24 domain.
module jtcop_mcu_mbox #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter bit SYNC  = 1'b1
) (
    input  logic           rst24,
    input  logic           clk24,
    jtcop_mcu_mbox_if.slave mbox
);
    localparam int LANES = DW / 8;
    localparam int CW    = $clog2(DEPTH);
    localparam logic [CW:0] FULL_LVL = (CW+1)'(DEPTH);

    logic          we_s;
    logic          we_l_q;
    logic          pop_l_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic [CW-1:0] hd_q, hd_d;
    logic [CW-1:0] tl_q, tl_d;
    logic [CW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          full_q;
    logic          intn_q;
    logic [7:0]    p0i_q;
    logic [7:0]    rd_byte;
    logic [DW-1:0] dout_q;
    logic          push_edge, pop_edge;
    logic          push_eff, pop_eff, drop;

    // ---- main_we capture: optional 2-flop synchroniser ----
    if (SYNC) begin : g_sync
        logic we_p0_q, we_p1_q;
        always_ff @(posedge clk24 or posedge rst24) begin
            if (rst24) begin
                we_p0_q <= 1'b0;
                we_p1_q <= 1'b0;
            end else begin
                we_p0_q <= mbox.main_we;
                we_p1_q <= we_p0_q;
            end
        end
        assign we_s = we_p1_q;
    end else begin : g_nosync
        assign we_s = mbox.main_we;
    end

    assign push_edge = we_s & ~we_l_q;
    assign pop_edge  = mbox.mcu_pop & ~pop_l_q;

    // ---- FIFO next state ----
    // A full FIFO still accepts a push when a pop retires the head in the same cycle.
    always_comb begin
        pop_eff  = pop_edge && (level_q != '0);
        push_eff = push_edge && ((level_q != FULL_LVL) || pop_eff);
        drop     = push_edge && !push_eff;
        hd_d     = pop_eff  ? hd_q + 1'b1 : hd_q;
        tl_d     = push_eff ? tl_q + 1'b1 : tl_q;
        level_d  = level_q;
        if (push_eff && !pop_eff)
            level_d = level_q + 1'b1;
        else if (pop_eff && !push_eff)
            level_d = level_q - 1'b1;
        ovf_d = ovf_q;
        if (drop)
            ovf_d = 1'b1;
        else if (mbox.mcu_clr)
            ovf_d = 1'b0;
    end

    // Head-entry byte for the MCU; out-of-range lanes and an empty FIFO read all ones.
    always_comb begin
        rd_byte = 8'hFF;
        if (level_q != '0) begin
            for (int i = 0; i < LANES; i++) begin
                if (int'(mbox.mcu_lane) == i)
                    rd_byte = mem_q[hd_q][8*i +: 8];
            end
        end
    end

    // Storage carries no reset so it can map onto plain registers or distributed RAM.
    always_ff @(posedge clk24) begin
        if (push_eff)
            mem_q[tl_q] <= mbox.main_din;
    end

    // ---- control, flags and registered outputs ----
    always_ff @(posedge clk24 or posedge rst24) begin
        if (rst24) begin
            we_l_q  <= 1'b0;
            pop_l_q <= 1'b0;
            hd_q    <= '0;
            tl_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            full_q  <= 1'b0;
            intn_q  <= 1'b1;
            p0i_q   <= 8'h00;
            dout_q  <= '0;
        end else begin
            we_l_q  <= we_s;
            pop_l_q <= mbox.mcu_pop;
            hd_q    <= hd_d;
            tl_q    <= tl_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            full_q  <= (level_d == FULL_LVL);
            intn_q  <= (level_d == '0);
            if (mbox.mcu_rd)
                p0i_q <= rd_byte;
            for (int i = 0; i < LANES; i++) begin
                if (mbox.mcu_wr && (int'(mbox.mcu_lane) == i))
                    dout_q[8*i +: 8] <= mbox.mcu_p0o;
            end
        end
    end

    assign mbox.main_dout = dout_q;
    assign mbox.full      = full_q;
    assign mbox.level     = level_q;
    assign mbox.ovf       = ovf_q;
    assign mbox.mcu_p0i   = p0i_q;
    assign mbox.mcu_intn  = intn_q;
endmodule

// File: tb/tb_jtcop_mcu_mbox.sv
// Bench for jtcop_mcu_mbox: a DW=16/DEPTH=4/SYNC=1 instance and a DW=32/DEPTH=8/SYNC=0 instance.
// Queues hold the words pushed; reads and pops are compared against the queue head.
module tb_jtcop_mcu_mbox;
    logic clk24 = 1'b0;
    logic rst24 = 1'b1;
    always #5 clk24 = ~clk24;

    jtcop_mcu_mbox_if #(.DW(16), .DEPTH(4)) a_if ();
    jtcop_mcu_mbox_if #(.DW(32), .DEPTH(8)) b_if ();

    jtcop_mcu_mbox #(.DW(16), .DEPTH(4), .SYNC(1'b1)) u_a (
        .rst24(rst24), .clk24(clk24), .mbox(a_if.slave));
    jtcop_mcu_mbox #(.DW(32), .DEPTH(8), .SYNC(1'b0)) u_b (
        .rst24(rst24), .clk24(clk24), .mbox(b_if.slave));

    typedef struct {
        bit          sel_b;
        logic [1:0]  lane;
        logic [7:0]  bval;
        logic [31:0] exp;
    } wr_vec_t;

    wr_vec_t     wv [8];
    logic [15:0] qa [$];
    logic [31:0] qb [$];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk24);
        #1;
    endtask

    task automatic idle();
        a_if.main_we = 1'b0; a_if.main_din = '0; a_if.mcu_lane = '0; a_if.mcu_rd = 1'b0;
        a_if.mcu_wr = 1'b0;  a_if.mcu_pop = 1'b0; a_if.mcu_clr = 1'b0; a_if.mcu_p0o = 8'h00;
        b_if.main_we = 1'b0; b_if.main_din = '0; b_if.mcu_lane = '0; b_if.mcu_rd = 1'b0;
        b_if.mcu_wr = 1'b0;  b_if.mcu_pop = 1'b0; b_if.mcu_clr = 1'b0; b_if.mcu_p0o = 8'h00;
    endtask

    // SYNC=1: the push lands on the third edge; lowering needs three more to clear the history.
    task automatic push_a(input logic [15:0] d);
        a_if.main_din = d; a_if.main_we = 1'b1;
        step(3);
        if (qa.size() < 4) qa.push_back(d);
        a_if.main_we = 1'b0;
        step(3);
    endtask

    task automatic push_b(input logic [31:0] d);
        b_if.main_din = d; b_if.main_we = 1'b1;
        step();
        if (qb.size() < 8) qb.push_back(d);
        b_if.main_we = 1'b0;
        step();
    endtask

    task automatic readpop_a();
        logic [15:0] exp;
        exp = (qa.size() > 0) ? qa[0] : 16'hFFFF;
        a_if.mcu_rd = 1'b1; a_if.mcu_lane = 1'b0;
        step();
        chk("a_rd_lane0", 32'(a_if.mcu_p0i), 32'(exp[7:0]));
        a_if.mcu_lane = 1'b1;
        step();
        chk("a_rd_lane1", 32'(a_if.mcu_p0i), 32'(exp[15:8]));
        a_if.mcu_rd = 1'b0; a_if.mcu_lane = 1'b0; a_if.mcu_pop = 1'b1;
        step();
        a_if.mcu_pop = 1'b0;
        if (qa.size() > 0) qa.delete(0);
        chk("a_rd_hold", 32'(a_if.mcu_p0i), 32'(exp[15:8]));
        chk("a_level_after_pop", 32'(a_if.level), 32'(qa.size()));
        step();
    endtask

    task automatic readpop_b();
        logic [31:0] exp;
        exp = (qb.size() > 0) ? qb[0] : 32'hFFFF_FFFF;
        b_if.mcu_rd = 1'b1;
        for (int l = 0; l < 4; l++) begin
            b_if.mcu_lane = 2'(l);
            step();
            chk("b_rd_lane", 32'(b_if.mcu_p0i), 32'(exp[8*l +: 8]));
        end
        b_if.mcu_rd = 1'b0; b_if.mcu_pop = 1'b1;
        step();
        b_if.mcu_pop = 1'b0;
        if (qb.size() > 0) qb.delete(0);
        chk("b_level_after_pop", 32'(b_if.level), 32'(qb.size()));
        step();
    endtask

    initial begin
        wv[0] = '{1'b0, 2'd0, 8'h34, 32'h0000_0034};
        wv[1] = '{1'b0, 2'd1, 8'h12, 32'h0000_1234};
        wv[2] = '{1'b0, 2'd0, 8'hCD, 32'h0000_12CD};
        wv[3] = '{1'b1, 2'd0, 8'hEF, 32'h0000_00EF};
        wv[4] = '{1'b1, 2'd2, 8'hAD, 32'h00AD_00EF};
        wv[5] = '{1'b1, 2'd3, 8'hDE, 32'hDEAD_00EF};
        wv[6] = '{1'b1, 2'd1, 8'hBE, 32'hDEAD_BEEF};
        wv[7] = '{1'b1, 2'd3, 8'h5A, 32'h5AAD_BEEF};

        idle();
        rst24 = 1'b1;
        step(3);
        rst24 = 1'b0;
        step();
        chk("a_rst_intn",  32'(a_if.mcu_intn), 32'd1);
        chk("a_rst_level", 32'(a_if.level),    32'd0);
        chk("a_rst_full",  32'(a_if.full),     32'd0);
        chk("a_rst_ovf",   32'(a_if.ovf),      32'd0);
        chk("a_rst_dout",  32'(a_if.main_dout), 32'd0);
        chk("a_rst_p0i",   32'(a_if.mcu_p0i),  32'd0);
        chk("b_rst_intn",  32'(b_if.mcu_intn), 32'd1);

        // Single push, 3-cycle latency through the synchroniser
        a_if.main_din = 16'hA55A; a_if.main_we = 1'b1;
        step();
        chk("a_lat_edge1", 32'(a_if.level), 32'd0);
        step();
        chk("a_lat_edge2", 32'(a_if.level), 32'd0);
        step();
        chk("a_lat_edge3", 32'(a_if.level), 32'd1);
        qa.push_back(16'hA55A);
        step();
        chk("a_intn_pending", 32'(a_if.mcu_intn), 32'd0);
        a_if.main_we = 1'b0;
        step(3);
        readpop_a();
        chk("a_intn_drained", 32'(a_if.mcu_intn), 32'd1);

        // Overflow: fifth word dropped, sticky ovf, order preserved
        for (int i = 1; i <= 5; i++) push_a(16'(i));
        chk("a_ovf_full",  32'(a_if.full),  32'd1);
        chk("a_ovf_flag",  32'(a_if.ovf),   32'd1);
        chk("a_ovf_level", 32'(a_if.level), 32'd4);
        for (int i = 0; i < 4; i++) readpop_a();
        chk("a_ovf_sticky", 32'(a_if.ovf), 32'd1);
        a_if.mcu_clr = 1'b1;
        step();
        a_if.mcu_clr = 1'b0;
        chk("a_ovf_clr", 32'(a_if.ovf), 32'd0);

        // Coincident push and pop while full
        for (int i = 0; i < 4; i++) push_a(16'h0010 + 16'(i));
        a_if.main_din = 16'hBEEF; a_if.main_we = 1'b1;
        step(2);
        a_if.mcu_pop = 1'b1;
        step();
        chk("a_coin_full_level", 32'(a_if.level), 32'd4);
        chk("a_coin_full_ovf",   32'(a_if.ovf),   32'd0);
        qa.delete(0);
        qa.push_back(16'hBEEF);
        a_if.mcu_pop = 1'b0; a_if.main_we = 1'b0;
        step(3);
        for (int i = 0; i < 4; i++) readpop_a();

        // Coincident push and pop while empty: pop ignored
        a_if.main_din = 16'h7E57; a_if.main_we = 1'b1;
        step(2);
        a_if.mcu_pop = 1'b1;
        step();
        chk("a_coin_empty_level", 32'(a_if.level), 32'd1);
        qa.push_back(16'h7E57);
        a_if.mcu_pop = 1'b0; a_if.main_we = 1'b0;
        step(3);
        readpop_a();

        // Reply register, byte lane at a time
        foreach (wv[k]) begin
            if (wv[k].sel_b) begin
                b_if.mcu_lane = wv[k].lane; b_if.mcu_p0o = wv[k].bval; b_if.mcu_wr = 1'b1;
                step();
                b_if.mcu_wr = 1'b0;
                chk("b_reply", b_if.main_dout, wv[k].exp);
            end else begin
                a_if.mcu_lane = wv[k].lane[0]; a_if.mcu_p0o = wv[k].bval; a_if.mcu_wr = 1'b1;
                step();
                a_if.mcu_wr = 1'b0;
                chk("a_reply", 32'(a_if.main_dout), wv[k].exp);
            end
        end

        // Empty read and empty pop
        a_if.mcu_rd = 1'b1; a_if.mcu_lane = 1'b1;
        step();
        chk("a_empty_rd", 32'(a_if.mcu_p0i), 32'h0000_00FF);
        a_if.mcu_rd = 1'b0; a_if.mcu_pop = 1'b1;
        step();
        a_if.mcu_pop = 1'b0;
        chk("a_empty_pop_level", 32'(a_if.level),    32'd0);
        chk("a_empty_pop_intn",  32'(a_if.mcu_intn), 32'd1);
        chk("a_empty_pop_ovf",   32'(a_if.ovf),      32'd0);
        step();

        // Wide instance, no synchroniser: 1-cycle latency
        b_if.main_din = 32'hDEAD_BEEF; b_if.main_we = 1'b1;
        step();
        chk("b_lat_edge1", 32'(b_if.level), 32'd1);
        qb.push_back(32'hDEAD_BEEF);
        b_if.main_we = 1'b0;
        step();
        chk("b_intn_pending", 32'(b_if.mcu_intn), 32'd0);
        readpop_b();
        chk("b_intn_drained", 32'(b_if.mcu_intn), 32'd1);

        // Nine pushes from head=1: tail wraps, ninth word dropped
        for (int i = 0; i < 9; i++) push_b(32'h1000_0000 + 32'(i));
        chk("b_ovf_full",  32'(b_if.full),  32'd1);
        chk("b_ovf_flag",  32'(b_if.ovf),   32'd1);
        chk("b_ovf_level", 32'(b_if.level), 32'd8);
        for (int i = 0; i < 8; i++) readpop_b();
        b_if.mcu_clr = 1'b1;
        step();
        b_if.mcu_clr = 1'b0;
        chk("b_ovf_clr", 32'(b_if.ovf), 32'd0);
        for (int i = 0; i < 3; i++) push_b(32'hC0DE_0000 + 32'(i));
        for (int i = 0; i < 3; i++) readpop_b();

        // Asynchronous reset in the middle of a burst
        push_a(16'h1111);
        push_b(32'h2222_2222);
        push_b(32'h3333_3333);
        a_if.main_din = 16'h4444; a_if.main_we = 1'b1;
        b_if.main_din = 32'h5555_5555; b_if.main_we = 1'b1;
        step();
        #2 rst24 = 1'b1;
        #1;
        chk("a_midrst_intn",  32'(a_if.mcu_intn),  32'd1);
        chk("a_midrst_level", 32'(a_if.level),     32'd0);
        chk("a_midrst_full",  32'(a_if.full),      32'd0);
        chk("a_midrst_ovf",   32'(a_if.ovf),       32'd0);
        chk("a_midrst_dout",  32'(a_if.main_dout), 32'd0);
        chk("a_midrst_p0i",   32'(a_if.mcu_p0i),   32'd0);
        chk("b_midrst_intn",  32'(b_if.mcu_intn),  32'd1);
        chk("b_midrst_level", 32'(b_if.level),     32'd0);
        chk("b_midrst_dout",  b_if.main_dout,      32'd0);
        chk("b_midrst_p0i",   32'(b_if.mcu_p0i),   32'd0);
        idle();
        qa.delete();
        qb.delete();
        step(2);
        rst24 = 1'b0;
        step(2);
        chk("a_postrst_level", 32'(a_if.level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
